aux_arc_reduce: RTL and testbench
=================================

# aux_arc_reduce

Parametrised successor to the single-cycle auxiliary arc stub. It performs a real memory-side reduction for the core's auxiliary port. On an `aux_en` request it streams `aux_len` words from `aux_start_addr` through the auxiliary memory port and folds them with a selectable operator (sum, xor, max, min). It then optionally writes the result to the word after the block and signals `aux_done`. It sits between the core's aux command interface and the shared data memory port.

## Interface
Parameters:
- `XLEN`, default `RV_BIT_NUM` (32): data and address width.
- `LEN_W`, default 16: width of the word-count input.
- `RD_LAT`, default 1: memory read latency in cycles, ≥1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `aux_mem_keep`, output, XLEN/8: byte write strobes; all-zero means read.
- `aux_mem_datai`, output, XLEN: write data to memory.
- `aux_mem_addr`, output, XLEN: byte address.
- `aux_mem_datao`, input, XLEN: read data, valid RD_LAT cycles after its address.
- `aux_start_addr`, input, XLEN: block base byte address; word aligned.
- `aux_len`, input, LEN_W: number of words.
- `aux_mode`, input, 2: 0 = sum mod 2^XLEN, 1 = xor, 2 = unsigned max, 3 = unsigned min.
- `aux_en`, input, 1: request level.
- `aux_busy`, output, 1: high from accept until DONE.
- `aux_result`, output, XLEN: last reduction result; holds until the next accept.
- `aux_done`, output, 1: completion.

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE with `aux_en`=1:
  - Capture addr, len and mode.
  - Load the accumulator with the mode identity: 0, 0, 0 and all-ones respectively.
  - Go to READ, or to WRITE if len = 0.
- READ:
  - One read per cycle: `aux_mem_addr` = base + i·(XLEN/8), keep = 0.
  - Address wraps modulo 2^XLEN.
  - After the len-th address, go to DRAIN.
- DRAIN:
  - An RD_LAT-deep valid shift register tracks in-flight reads.
  - Each returning word is folded into the accumulator. `aux_arc_alu` handles back-to-back words, one per cycle.
  - When received count = len, go to WRITE.
- WRITE (writeback build):
  - Single cycle: addr = base + len·(XLEN/8), keep all-ones, datai = accumulator.
  - `aux_result` updates on the same edge.
- DONE:
  - `aux_done`=1 and `aux_busy`=0.
  - Stay while `aux_en`=1; return to IDLE when `aux_en`=0.
  - If `aux_en` is already low, `aux_done` is a 1-cycle pulse.
- `aux_en` dropping mid-operation is ignored; the operation completes.
- `aux_en` held high through DONE→IDLE does not restart. A new accept needs `aux_en` to be seen low in DONE first.
- Outside READ and WRITE: addr = 0, keep = 0, datai = 0.
- Input changes after accept have no effect.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE, all outputs including `aux_result` go to 0, and in-flight reads are discarded. This applies mid-operation too.
- Cycle 0 is the edge that samples `aux_en` in IDLE.
- First read address appears in cycle 1; the last in cycle N.
- The last word is folded at the end of cycle N+RD_LAT.
- WRITE occurs in cycle N+RD_LAT+1.
- `aux_done` rises in cycle N+RD_LAT+2.
- len = 0: WRITE in cycle 1, done in cycle 2.
- `aux_busy` is high from cycle 1 until the cycle before done.

## Configuration
- Macro `AUX_ARC_WRITEBACK_EN`.
- Defined: WRITE state is present, so the result is stored to memory.
- Undefined: WRITE is removed. DRAIN goes to DONE (and len = 0 goes IDLE→DONE). `aux_result` is updated on the final fold. Done comes one cycle earlier: N+RD_LAT+1, or cycle 1 for len = 0. keep is never non-zero.

## Structure
- Package `aux_arc_pkg`:
  - FSM state encoding.
  - Mode codes `AUX_MODE_SUM/XOR/MAX/MIN`.
  - Identity constant function per mode.
- Sub-module `aux_arc_alu`: combinational (acc, word, mode) → new acc.
- Top holds the FSM, issue/receive counters and the latency shift register.

## Test plan
- Reset mid-READ, with len = 8 and `rst_n` low at cycle 3 → next cycle all outputs 0 and state IDLE; a subsequent request runs cleanly.
- SUM, base 0x100, len 4, words 1, 2, 3, 0xFFFFFFFF, RD_LAT = 1 → reads 0x100–0x10C in cycles 1–4; write of 0x00000005 to 0x110 in cycle 6; done in cycle 7.
- MIN, len 0 → no reads; write of 0xFFFFFFFF to base in cycle 1; done in cycle 2.
- XOR, RD_LAT = 3, len 3, words 0xF0, 0x0F, 0xFF → result 0x00; done in cycle 3+3+2 = 8.
- MAX with base 0xFFFFFFF8, len 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; result is the max; `aux_en` held high keeps done high, then drop → IDLE with no restart.
- Build without `AUX_ARC_WRITEBACK_EN`, SUM len 2, words 7 and 9 → keep stays 0; `aux_result` = 16; done in cycle 4.

Source files
------------

// File: rtl/aux_arc_pkg.sv
// Shared types for the auxiliary arc reduction engine: FSM encoding, fold modes
// and the per-mode accumulator identity.
package aux_arc_pkg;

  localparam int RV_BIT_NUM = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } aux_state_t;

  localparam logic [1:0] AUX_MODE_SUM = 2'd0;
  localparam logic [1:0] AUX_MODE_XOR = 2'd1;
  localparam logic [1:0] AUX_MODE_MAX = 2'd2;
  localparam logic [1:0] AUX_MODE_MIN = 2'd3;

  // Every identity is either all-zeros or all-ones, so callers replicate this bit to XLEN.
  function automatic logic aux_mode_identity_fill(input logic [1:0] mode);
    return (mode == AUX_MODE_MIN);
  endfunction

endpackage

// File: rtl/aux_arc_alu.sv
// Combinational fold step: merges one returned memory word into the accumulator.
// Zero latency, so back-to-back words fold one per cycle.
module aux_arc_alu
  import aux_arc_pkg::*;
#(
  parameter int XLEN = RV_BIT_NUM
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      mode,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = acc;
    case (mode)
      AUX_MODE_SUM: result = acc + word;
      AUX_MODE_XOR: result = acc ^ word;
      AUX_MODE_MAX: result = (word > acc) ? word : acc;
      AUX_MODE_MIN: result = (word < acc) ? word : acc;
      default:      result = acc;
    endcase
  end

endmodule

// File: rtl/aux_arc_reduce.sv
// Streams aux_len words from memory, folds them (sum/xor/max/min) and reports the result.
// Define AUX_ARC_WRITEBACK_EN to also store the result to the word following the block.
module aux_arc_reduce
  import aux_arc_pkg::*;
#(
  parameter int XLEN   = RV_BIT_NUM,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN/8-1:0] aux_mem_keep,
  output logic [XLEN-1:0]   aux_mem_datai,
  output logic [XLEN-1:0]   aux_mem_addr,
  input  logic [XLEN-1:0]   aux_mem_datao,
  input  logic [XLEN-1:0]   aux_start_addr,
  input  logic [LEN_W-1:0]  aux_len,
  input  logic [1:0]        aux_mode,
  input  logic              aux_en,
  output logic              aux_busy,
  output logic [XLEN-1:0]   aux_result,
  output logic              aux_done
);

  localparam logic [XLEN-1:0] STRIDE = XLEN'(XLEN / 8);

  aux_state_t        state, state_nxt;
  logic [XLEN-1:0]   addr_q, acc_q, acc_nxt, result_q, identity;
  logic [LEN_W-1:0]  len_q, iss_cnt, rcv_cnt;
  logic [1:0]        mode_q;
  logic [RD_LAT-1:0] vld_sr;
  logic              accept, issue, fold, last_iss, last_fold;

  assign accept    = (state == ST_IDLE) && aux_en;
  assign issue     = (state == ST_READ);
  assign fold      = vld_sr[RD_LAT-1];
  assign last_iss  = issue && (iss_cnt == len_q - LEN_W'(1));
  assign last_fold = fold && (rcv_cnt == len_q - LEN_W'(1));
  assign identity  = {XLEN{aux_mode_identity_fill(aux_mode)}};

  aux_arc_alu #(.XLEN(XLEN)) u_alu (
    .acc    (acc_q),
    .word   (aux_mem_datao),
    .mode   (mode_q),
    .result (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (aux_en) begin
`ifdef AUX_ARC_WRITEBACK_EN
          state_nxt = (aux_len == '0) ? ST_WRITE : ST_READ;
`else
          state_nxt = (aux_len == '0) ? ST_DONE : ST_READ;
`endif
        end
      end
      ST_READ:  if (last_iss) state_nxt = ST_DRAIN;
`ifdef AUX_ARC_WRITEBACK_EN
      ST_DRAIN: if (last_fold) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_DONE;
`else
      ST_DRAIN: if (last_fold) state_nxt = ST_DONE;
`endif
      // Leaving DONE only on a low aux_en stops a held request from re-triggering.
      ST_DONE:  if (!aux_en) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      iss_cnt  <= '0;
      rcv_cnt  <= '0;
      vld_sr   <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
      if (accept) begin
        addr_q  <= aux_start_addr;
        len_q   <= aux_len;
        mode_q  <= aux_mode;
        acc_q   <= identity;
        iss_cnt <= '0;
        rcv_cnt <= '0;
      end
      // addr_q ends up at base + len*stride, which is exactly the writeback slot.
      if (issue) begin
        addr_q  <= addr_q + STRIDE;
        iss_cnt <= iss_cnt + LEN_W'(1);
      end
      if (fold) begin
        acc_q   <= acc_nxt;
        rcv_cnt <= rcv_cnt + LEN_W'(1);
      end
`ifdef AUX_ARC_WRITEBACK_EN
      if (state == ST_WRITE) result_q <= acc_q;
`else
      if (last_fold) result_q <= acc_nxt;
      else if (accept && aux_len == '0) result_q <= identity;
`endif
    end
  end

  always_comb begin
    aux_mem_addr  = '0;
    aux_mem_keep  = '0;
    aux_mem_datai = '0;
    aux_busy      = 1'b0;
    aux_done      = 1'b0;
    case (state)
      ST_READ: begin
        aux_mem_addr = addr_q;
        aux_busy     = 1'b1;
      end
      ST_DRAIN: aux_busy = 1'b1;
`ifdef AUX_ARC_WRITEBACK_EN
      ST_WRITE: begin
        aux_mem_addr  = addr_q;
        aux_mem_keep  = '1;
        aux_mem_datai = acc_q;
        aux_busy      = 1'b1;
      end
`endif
      ST_DONE: aux_done = 1'b1;
      default: ;
    endcase
  end

  assign aux_result = result_q;

endmodule

// File: tb/tb_aux_arc_reduce.sv
// Randomised scoreboard bench for aux_arc_reduce: expected bus trace and completion are
// queued at issue time and checked by an independent negedge monitor.
module tb_aux_arc_reduce;

  localparam int XLEN   = 32;
  localparam int LEN_W  = 16;
  localparam int RD_LAT = 3;
`ifdef AUX_ARC_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        aux_mem_keep;
  logic [31:0]       aux_mem_datai, aux_mem_addr, aux_mem_datao;
  logic [31:0]       aux_start_addr = '0;
  logic [LEN_W-1:0]  aux_len = '0;
  logic [1:0]        aux_mode = '0;
  logic              aux_en = 1'b0;
  logic              aux_busy, aux_done;
  logic [31:0]       aux_result;

  always #5 clk = ~clk;

  aux_arc_reduce #(.XLEN(XLEN), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .aux_mem_keep   (aux_mem_keep),
    .aux_mem_datai  (aux_mem_datai),
    .aux_mem_addr   (aux_mem_addr),
    .aux_mem_datao  (aux_mem_datao),
    .aux_start_addr (aux_start_addr),
    .aux_len        (aux_len),
    .aux_mode       (aux_mode),
    .aux_en         (aux_en),
    .aux_busy       (aux_busy),
    .aux_result     (aux_result),
    .aux_done       (aux_done)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  keep;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic [31:0] edge_n;
    logic [31:0] res;
  } done_t;

  bus_t        trace_q[$];
  done_t       done_q[$];
  bus_t        mon_e;
  done_t       mon_d;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [RD_LAT];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ecnt = '0;
  bit          chk_en = 1'b0;
  logic        done_prev = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(posedge clk) ecnt <= ecnt + 32'd1;

  // Memory with RD_LAT cycles of read latency; data is sampled when the address is issued.
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= rd(aux_mem_addr);
  end
  assign aux_mem_datao = rd_pipe[RD_LAT-1];

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (aux_busy) begin
        if (trace_q.size() == 0) check("extra_busy_cycle", 32'(aux_busy), 32'd0);
        else begin
          mon_e = trace_q.pop_front();
          check("bus_addr", aux_mem_addr, mon_e.addr);
          check("bus_keep", 32'(aux_mem_keep), 32'(mon_e.keep));
          check("bus_datai", aux_mem_datai, mon_e.dat);
        end
      end else begin
        check("idle_bus", aux_mem_addr | aux_mem_datai | 32'(aux_mem_keep), 32'd0);
      end
      if (aux_done && !done_prev) begin
        if (done_q.size() == 0) check("extra_done", 32'(aux_done), 32'd0);
        else begin
          mon_d = done_q.pop_front();
          check("done_edge", ecnt, mon_d.edge_n);
          check("result", aux_result, mon_d.res);
          check("trace_left", 32'(trace_q.size()), 32'd0);
        end
      end
    end
    done_prev = aux_done;
  end

  task automatic run_op(input logic [31:0] base, input int len, input logic [1:0] mode,
                        input int hold);
    logic [31:0] acc, w, a0;
    int          lat;
    bit          seen;
    acc = (mode == 2'd3) ? 32'hFFFF_FFFF : 32'h0;
    for (int i = 0; i < len; i++) begin
      w = rd(base + 32'(4 * i));
      case (mode)
        2'd0: acc = acc + w;
        2'd1: acc = acc ^ w;
        2'd2: acc = (w > acc) ? w : acc;
        default: acc = (w < acc) ? w : acc;
      endcase
    end
    lat = ((len > 0) ? len + RD_LAT : 0) + (WB ? 1 : 0) + 1;
    @(negedge clk);
    aux_start_addr = base;
    aux_len        = LEN_W'(len);
    aux_mode       = mode;
    aux_en         = 1'b1;
    @(posedge clk);
    #1;
    a0 = ecnt;
    for (int i = 0; i < len; i++) trace_q.push_back({base + 32'(4 * i), 4'h0, 32'h0});
    if (len > 0) for (int i = 0; i < RD_LAT; i++) trace_q.push_back({32'h0, 4'h0, 32'h0});
    if (WB) trace_q.push_back({base + 32'(4 * len), 4'hF, acc});
    done_q.push_back({a0 + 32'(lat) - 32'd1, acc});
    aux_start_addr = $urandom;
    aux_len        = LEN_W'($urandom);
    aux_mode       = 2'($urandom);
    if (hold == 0) aux_en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < lat + 20 && !seen; k++) begin
      @(negedge clk);
      seen = aux_done;
    end
    if (!seen) check("done_timeout", 32'(aux_done), 32'd1);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("done_held", 32'(aux_done), 32'd1);
        check("busy_in_done", 32'(aux_busy), 32'd0);
      end
      aux_en = 1'b0;
    end
    @(negedge clk);
    check("done_release", 32'(aux_done), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("no_restart", 32'(aux_busy) | 32'(aux_done), 32'd0);
    end
  endtask

  task automatic fill_rand(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) mem[base + 32'(4 * i)] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", aux_mem_addr, 32'd0);
    check("rst_ctl", {aux_mem_datai[30:0], 1'b0} | 32'(aux_mem_keep) | 32'(aux_busy) | 32'(aux_done), 32'd0);
    check("rst_result", aux_result, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    mem[32'h100] = 32'h1; mem[32'h104] = 32'h2; mem[32'h108] = 32'h3; mem[32'h10C] = 32'hFFFF_FFFF;
    run_op(32'h100, 4, 2'd0, 0);

    // Reset in cycle 3 of an 8-word read.
    fill_rand(32'h2000, 8);
    chk_en = 1'b0;
    @(negedge clk);
    aux_start_addr = 32'h2000; aux_len = LEN_W'(8); aux_mode = 2'd0; aux_en = 1'b1;
    @(posedge clk);
    #1 aux_en = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(aux_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_addr", aux_mem_addr, 32'd0);
    check("midrst_ctl", 32'(aux_mem_keep) | 32'(aux_busy) | 32'(aux_done), 32'd0);
    check("midrst_result", aux_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    run_op(32'h400, 0, 2'd3, 0);
    mem[32'h500] = 32'hF0; mem[32'h504] = 32'h0F; mem[32'h508] = 32'hFF;
    run_op(32'h500, 3, 2'd1, 0);
    fill_rand(32'hFFFF_FFF8, 3);
    run_op(32'hFFFF_FFF8, 3, 2'd2, 3);
    mem[32'h600] = 32'd7; mem[32'h604] = 32'd9;
    run_op(32'h600, 2, 2'd0, 0);
    run_op(32'h700, 0, 2'd0, 2);

    for (int t = 0; t < 30; t++) begin
      int len;
      base = {$urandom, 2'b00};
      if (t % 7 == 0) base = 32'hFFFF_FFF0;
      len = $urandom_range(0, 12);
      fill_rand(base, len);
      run_op(base, len, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
    end

    repeat (3) @(negedge clk);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    check("trace_queue_empty", 32'(trace_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
